// File: rtl/risc_pkg.sv
// Shared definitions for the RISC datapath: opcode constants, controller state
// encoding and the bundle of control strobes produced by the decode.
package risc_pkg;

  typedef enum logic [2:0] {
    HLT = 3'b000,
    SKZ = 3'b001,
    ADD = 3'b010,
    AND = 3'b011,
    XOR = 3'b100,
    LDA = 3'b101,
    STO = 3'b110,
    JMP = 3'b111
  } opcode_e;

  // Numbered states double as the externally visible phase; HALTED sits outside 0..7.
  typedef enum logic [3:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    IDLE       = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    HALTED     = 4'd8
  } state_e;

  typedef struct packed {
    logic sel;
    logic rd;
    logic wr;
    logic ld_ir;
    logic ld_ac;
    logic inc_pc;
    logic ld_pc;
    logic data_e;
    logic halt;
  } ctrl_t;

  // Opcodes that read an operand from memory and write the accumulator.
  function automatic logic is_aluop(opcode_e op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/risc_ctrl_decode.sv
// Combinational decode of controller state and opcode into datapath strobes
// and the externally visible phase number.
module risc_ctrl_decode
  import risc_pkg::*;
(
  input  state_e      state,
  input  opcode_e     opcd,
  input  logic        zr,
  output ctrl_t       ctrl,
  output logic [2:0]  phase
);

  logic alu;

  assign alu = is_aluop(opcd);

  always_comb begin
    // NOTE: every strobe gets a default before the case so no path can infer a latch.
    ctrl = '0;
    case (state)
      INST_ADDR:  ctrl.sel = 1'b1;
      INST_FETCH: begin
        ctrl.sel = 1'b1;
        ctrl.rd  = 1'b1;
      end
      INST_LOAD, IDLE: begin
        ctrl.sel   = 1'b1;
        ctrl.rd    = 1'b1;
        ctrl.ld_ir = 1'b1;
      end
      OP_ADDR: begin
        ctrl.inc_pc = 1'b1;
        ctrl.halt   = (opcd == HLT);
      end
      OP_FETCH:   ctrl.rd = alu;
      ALU_OP: begin
        ctrl.rd     = alu;
        ctrl.inc_pc = (opcd == SKZ) && zr;
        ctrl.ld_pc  = (opcd == JMP);
        ctrl.data_e = (opcd == STO);
      end
      STORE: begin
        ctrl.rd     = alu;
        ctrl.ld_ac  = alu;
        ctrl.ld_pc  = (opcd == JMP);
        ctrl.data_e = (opcd == STO);
        ctrl.wr     = (opcd == STO);
      end
      HALTED:     ctrl.halt = 1'b1;
      default:    ctrl = '0;
    endcase
  end

  assign phase = (state == HALTED) ? 3'd4 : state[2:0];

endmodule

// File: rtl/risc_controller.sv
// Eight-phase instruction sequencer for the RISC core: state register,
// retired-instruction counter and the control decode.
module risc_controller
  import risc_pkg::*;
(
  input  logic        aclk,
  input  logic        rst_n,
  input  logic [2:0]  opcd,
  input  logic        zr,
  input  logic        mem_rdy,
  input  logic        go,
  output logic        sel,
  output logic        rd,
  output logic        wr,
  output logic        ld_ir,
  output logic        ld_ac,
  output logic        inc_pc,
  output logic        ld_pc,
  output logic        data_e,
  output logic        halt,
  output logic [2:0]  phase,
  output logic [7:0]  instr_cnt
);

  state_e  state_q, state_d;
  opcode_e op;
  ctrl_t   ctrl;

  assign op = opcode_e'(opcd);

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= INST_ADDR;
      instr_cnt <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q <= state_d;
      // STORE always retires into INST_ADDR, so this counts completed instructions.
      if (state_q == STORE) instr_cnt <= instr_cnt + 8'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INST_ADDR:  state_d = INST_FETCH;
      INST_FETCH: if (mem_rdy) state_d = INST_LOAD;
      INST_LOAD:  state_d = IDLE;
      IDLE:       state_d = OP_ADDR;
      OP_ADDR:    state_d = (op == HLT) ? HALTED : OP_FETCH;
      OP_FETCH:   if (!is_aluop(op) || mem_rdy) state_d = ALU_OP;
      ALU_OP:     state_d = STORE;
      STORE:      state_d = INST_ADDR;
      HALTED:     if (go) state_d = INST_ADDR;
      default:    state_d = INST_ADDR;
    endcase
  end

  risc_ctrl_decode u_decode (
    .state (state_q),
    .opcd  (op),
    .zr    (zr),
    .ctrl  (ctrl),
    .phase (phase)
  );

  assign sel    = ctrl.sel;
  assign rd     = ctrl.rd;
  assign wr     = ctrl.wr;
  assign ld_ir  = ctrl.ld_ir;
  assign ld_ac  = ctrl.ld_ac;
  assign inc_pc = ctrl.inc_pc;
  assign ld_pc  = ctrl.ld_pc;
  assign data_e = ctrl.data_e;
  assign halt   = ctrl.halt;

endmodule

// File: tb/tb_risc_controller.sv
// Self-checking bench for risc_controller: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a phase model.
module tb_risc_controller;

  localparam logic [2:0] T_HLT = 3'd0, T_SKZ = 3'd1, T_ADD = 3'd2, T_AND = 3'd3,
                         T_XOR = 3'd4, T_LDA = 3'd5, T_STO = 3'd6, T_JMP = 3'd7;

  logic       aclk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] opcd = T_ADD;
  logic       zr = 1'b0, mem_rdy = 1'b1, go = 1'b0;
  logic       sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt;
  logic [2:0] phase;
  logic [7:0] instr_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  risc_controller dut (
    .aclk      (aclk),
    .rst_n     (rst_n),
    .opcd      (opcd),
    .zr        (zr),
    .mem_rdy   (mem_rdy),
    .go        (go),
    .sel       (sel),
    .rd        (rd),
    .wr        (wr),
    .ld_ir     (ld_ir),
    .ld_ac     (ld_ac),
    .inc_pc    (inc_pc),
    .ld_pc     (ld_pc),
    .data_e    (data_e),
    .halt      (halt),
    .phase     (phase),
    .instr_cnt (instr_cnt)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_alu(logic [2:0] op);
    return (op == T_ADD) || (op == T_AND) || (op == T_XOR) || (op == T_LDA);
  endfunction

  // Reference model: a phase number that advances by one per cycle except where stalled.
  int m_phase  = 0;
  bit m_halted = 1'b0;
  int m_cnt    = 0;

  always @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase  <= 0;
      m_halted <= 1'b0;
      m_cnt    <= 0;
    end else if (m_halted) begin
      if (go) begin
        m_halted <= 1'b0;
        m_phase  <= 0;
      end
    end else begin
      case (m_phase)
        1: if (mem_rdy) m_phase <= 2;
        4: if (opcd == T_HLT) m_halted <= 1'b1; else m_phase <= 5;
        5: if (!is_alu(opcd) || mem_rdy) m_phase <= 6;
        7: begin
          m_phase <= 0;
          m_cnt   <= (m_cnt + 1) % 256;
        end
        default: m_phase <= m_phase + 1;
      endcase
    end
  end

  // Expected {sel,rd,wr,ld_ir,ld_ac,inc_pc,ld_pc,data_e,halt,phase} from the phase rules.
  function automatic logic [11:0] expect_out(int ph, bit h, logic [2:0] op, logic z);
    bit alu = is_alu(op);
    bit run = !h;
    logic [2:0] p = h ? 3'd4 : 3'(ph);
    return {run && ph <= 3,
            run && ((ph >= 1 && ph <= 3) || (ph >= 5 && alu)),
            run && ph == 7 && op == T_STO,
            run && (ph == 2 || ph == 3),
            run && ph == 7 && alu,
            run && (ph == 4 || (ph == 6 && op == T_SKZ && z)),
            run && ph >= 6 && op == T_JMP,
            run && ph >= 6 && op == T_STO,
            h || (run && ph == 4 && op == T_HLT),
            p};
  endfunction

  always @(negedge aclk) begin
    check("model_outputs",
          32'({sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt, phase}),
          32'(expect_out(m_phase, m_halted, opcd, zr)));
    check("model_instr_cnt", 32'(instr_cnt), 32'(m_cnt));
    check("wr_rd_exclusive", 32'(wr & rd), 32'd0);
    check("pc_exclusive", 32'(ld_pc & inc_pc), 32'd0);
  end

  task automatic cyc();
    @(posedge aclk);
    #2;
  endtask

  // Run one instruction from phase 0 with no stalls, recording which phases raised each strobe.
  task automatic run_instr(input logic [2:0] op, input logic z,
                           output logic [7:0] r_inc, output logic [7:0] r_ldpc,
                           output logic [7:0] r_de, output logic [7:0] r_wr,
                           output logic [7:0] r_rd);
    int n = 0;
    opcd = op; zr = z; mem_rdy = 1'b1;
    r_inc = '0; r_ldpc = '0; r_de = '0; r_wr = '0; r_rd = '0;
    do begin
      r_inc[phase]  |= inc_pc;
      r_ldpc[phase] |= ld_pc;
      r_de[phase]   |= data_e;
      r_wr[phase]   |= wr;
      r_rd[phase]   |= rd;
      cyc();
      n++;
    end while (phase != 3'd0 && n < 40);
    check("instr_length", 32'(n), 32'd8);
  endtask

  initial begin
    logic [7:0] r_inc, r_ldpc, r_de, r_wr, r_rd;
    int n, stalls, p1;
    bit ok;

    repeat (3) cyc();
    check("reset_outputs",
          32'({sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt, phase}),
          32'(12'b1_0000_0000_000));
    check("reset_cnt", 32'(instr_cnt), 32'd0);

    // Reset release with ADD: phases 0..7 on consecutive cycles.
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("add_phase", 32'(phase), 32'(i));
      check("add_ld_ac", 32'(ld_ac), 32'(i == 7));
      cyc();
    end
    check("add_cnt", 32'(instr_cnt), 32'd1);

    // Three-cycle memory stall in INST_FETCH.
    n = 0; stalls = 0; p1 = 0;
    do begin
      if (phase == 3'd1) p1++;
      if (phase == 3'd1 && stalls < 3) begin
        mem_rdy = 1'b0;
        stalls++;
        check("stall_sel_rd", 32'({sel, rd}), 32'(2'b11));
      end else begin
        mem_rdy = 1'b1;
      end
      cyc();
      n++;
    end while (phase != 3'd0 && n < 50);
    mem_rdy = 1'b1;
    check("stall_length", 32'(n), 32'd11);
    check("stall_phase1_cycles", 32'(p1), 32'd4);
    check("stall_cnt", 32'(instr_cnt), 32'd2);

    run_instr(T_SKZ, 1'b1, r_inc, r_ldpc, r_de, r_wr, r_rd);
    check("skz_z1_inc_pc", 32'(r_inc), 32'h50);
    run_instr(T_SKZ, 1'b0, r_inc, r_ldpc, r_de, r_wr, r_rd);
    check("skz_z0_inc_pc", 32'(r_inc), 32'h10);
    run_instr(T_STO, 1'b0, r_inc, r_ldpc, r_de, r_wr, r_rd);
    check("sto_data_e", 32'(r_de), 32'hC0);
    check("sto_wr", 32'(r_wr), 32'h80);
    check("sto_rd_late", 32'(r_rd & 8'hF0), 32'h00);
    run_instr(T_JMP, 1'b0, r_inc, r_ldpc, r_de, r_wr, r_rd);
    check("jmp_ld_pc", 32'(r_ldpc), 32'hC0);
    check("seq_cnt", 32'(instr_cnt), 32'd6);

    // HLT: halt from OP_ADDR, hold with go=0, resume on go.
    opcd = T_HLT;
    repeat (4) cyc();
    check("hlt_op_addr", 32'({phase, halt, inc_pc}), 32'({3'd4, 1'b1, 1'b1}));
    cyc();
    check("hlt_halted", 32'({phase, halt, inc_pc, sel}), 32'({3'd4, 1'b1, 1'b0, 1'b0}));
    ok = 1'b1;
    repeat (20) begin
      go = 1'b0;
      cyc();
      if (phase != 3'd4 || !halt) ok = 1'b0;
    end
    check("hlt_hold_20", 32'(ok), 32'd1);
    go = 1'b1;
    cyc();
    go = 1'b0;
    opcd = T_ADD;
    check("go_resume", 32'({phase, halt}), 32'({3'd0, 1'b0}));
    check("go_cnt", 32'(instr_cnt), 32'd6);

    // Asynchronous reset in ALU_OP.
    repeat (6) cyc();
    check("pre_reset_phase", 32'(phase), 32'd6);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_phase", 32'(phase), 32'd0);
    check("async_reset_cnt", 32'(instr_cnt), 32'd0);
    cyc();
    rst_n = 1'b1;

    // Counter wrap after 256 retired instructions.
    repeat (255) run_instr(T_ADD, 1'b0, r_inc, r_ldpc, r_de, r_wr, r_rd);
    check("cnt_255", 32'(instr_cnt), 32'd255);
    run_instr(T_ADD, 1'b0, r_inc, r_ldpc, r_de, r_wr, r_rd);
    check("cnt_wrap", 32'(instr_cnt), 32'd0);

    // Randomized traffic, checked every cycle against the model.
    repeat (1500) begin
      opcd    = 3'($urandom_range(0, 7));
      zr      = 1'($urandom_range(0, 1));
      mem_rdy = ($urandom_range(0, 3) != 0);
      go      = ($urandom_range(0, 7) == 0);
      rst_n   = ($urandom_range(0, 299) != 0);
      cyc();
    end
    rst_n = 1'b1;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/risc_controller.md
RISC_CONTROLLER -- requirements
Module: risc_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; it SHALL have no parameters.
REQ-002 aclk  input  1  clock; all state changes occur on posedge aclk.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 opcd  input  3  current instruction opcode from the instruction register: HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111.
REQ-005 zr  input  1  accumulator zero flag from the alu.
REQ-006 mem_rdy  input  1  memory read-data-valid; 1 = read completes this cycle.
REQ-007 go  input  1  resume request while halted.
REQ-008 sel  output  1  1 = address mux selects PC, 0 = selects IR operand.
REQ-009 rd  output  1  memory read enable.
REQ-010 wr  output  1  memory write strobe.
REQ-011 ld_ir  output  1  instruction register load.
REQ-012 ld_ac  output  1  accumulator load from alu_out.
REQ-013 inc_pc  output  1  program counter increment.
REQ-014 ld_pc  output  1  program counter load from IR operand.
REQ-015 data_e  output  1  accumulator drives the data bus.
REQ-016 halt  output  1  processor halted.
REQ-017 phase  output  3  current phase number 0..7.
REQ-018 instr_cnt  output  8  retired-instruction count.

Function
REQ-019 The FSM states SHALL be INST_ADDR(0), INST_FETCH(1), INST_LOAD(2), IDLE(3), OP_ADDR(4), OP_FETCH(5), ALU_OP(6), STORE(7) and HALTED; phase SHALL show the number in parentheses and SHALL show 4 in HALTED.
REQ-020 The default transition SHALL be from each numbered phase to the next, with STORE returning to INST_ADDR.
REQ-021 INST_FETCH SHALL hold while mem_rdy=0 and advance only when mem_rdy=1.
REQ-022 For ALUOP opcodes (ADD, AND, XOR, LDA), OP_FETCH SHALL hold while mem_rdy=0.
REQ-023 For all other opcodes, OP_FETCH SHALL advance unconditionally.
REQ-024 In OP_ADDR with opcd=HLT, the next state SHALL be HALTED rather than OP_FETCH.
REQ-025 HALTED SHALL remain until go=1 is sampled; the next state SHALL then be INST_ADDR.
REQ-026 go SHALL be ignored in every state except HALTED.
REQ-027 Outputs SHALL be a combinational decode of the state register and opcd; any output not listed in REQ-028 to REQ-035 SHALL be 0.
REQ-028 INST_ADDR SHALL assert sel.
REQ-029 INST_FETCH SHALL assert sel and rd.
REQ-030 INST_LOAD and IDLE SHALL assert sel, rd and ld_ir.
REQ-031 OP_ADDR SHALL assert inc_pc, and SHALL also assert halt when opcd=HLT.
REQ-032 HALTED SHALL assert halt only.
REQ-033 OP_FETCH SHALL assert rd when the opcode is an ALUOP.
REQ-034 ALU_OP SHALL assert: rd=ALUOP; inc_pc=(opcd==SKZ and zr==1); ld_pc=(opcd==JMP); data_e=(opcd==STO).
REQ-035 STORE SHALL assert: rd=ALUOP; ld_ac=ALUOP; ld_pc=(opcd==JMP); data_e=(opcd==STO); wr=(opcd==STO).
REQ-036 wr and rd SHALL never be asserted together, and ld_pc and inc_pc SHALL never be asserted together.
REQ-037 instr_cnt SHALL increment by 1 on every STORE->INST_ADDR transition.
REQ-038 instr_cnt SHALL wrap from 255 to 0.
REQ-039 instr_cnt SHALL NOT increment for HLT.
REQ-040 A stall of any length SHALL keep all outputs stable at that phase's decode values.

Reset
REQ-041 While rst_n=0, the state SHALL be INST_ADDR and instr_cnt SHALL be 0, immediately and without waiting for aclk.
REQ-042 Outputs during reset SHALL therefore be sel=1, phase=0, and all other outputs 0.
REQ-043 Reset asserted mid-instruction, including during HALTED or a stall, SHALL abandon the instruction with no count increment.
REQ-044 After rst_n deasserts, the first state change SHALL occur on the next posedge aclk.

Structure
REQ-045 The opcode constants (HLT..JMP) and the state encoding SHALL live in the shared package risc_pkg, used by both this block and the alu.
REQ-046 The output decode SHALL be a sub-module, risc_ctrl_decode (state, opcd, zr -> control outputs); the state register and instr_cnt SHALL stay in risc_controller.

Verification
REQ-047 The bench SHALL cover: reset release with mem_rdy=1 and opcd=ADD -> phases 0..7 on eight consecutive cycles; ld_ac=1 only in phase 7; instr_cnt=1 after STORE.
REQ-048 The bench SHALL cover: mem_rdy=0 for 3 cycles in INST_FETCH -> phase stays 1 for 3 cycles with sel=rd=1, then proceeds; the instruction takes 11 cycles in total.
REQ-049 The bench SHALL cover: opcd=SKZ with zr=1 -> inc_pc=1 in phases 4 and 6; opcd=SKZ with zr=0 -> inc_pc=1 in phase 4 only.
REQ-050 The bench SHALL cover: opcd=STO -> data_e=1 in phases 6-7, wr=1 in phase 7 only, rd=0 throughout phases 4-7; opcd=JMP -> ld_pc=1 in phases 6-7.
REQ-051 The bench SHALL cover: opcd=HLT -> halt=1 from phase 4 onward, and state is held for 20 cycles with go=0.
REQ-052 The bench SHALL cover: a go pulse during HALTED -> INST_ADDR on the next cycle with instr_cnt unchanged.
REQ-053 The bench SHALL cover: 256 ADD instructions -> instr_cnt wraps to 0.
REQ-054 The bench SHALL cover: rst_n pulsed low in phase 6 -> phase=0 asynchronously, with instr_cnt=0.
